// File: rtl/mult_sequencer.sv
// Shift-add multiplier control sequencer: IDLE -> LOAD -> RUN (WORD_LENGTH cycles) -> DONE.
// Latency: start sampled at edge N gives done in cycle N+WORD_LENGTH+2; a one-cycle IDLE gap separates operations.
// Backpressure: none; start outside IDLE is ignored (flagged on err when MULT_SEQ_ERR_EN is defined).
module mult_sequencer #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   multiplier_lsb,
    output logic                   load,
    output logic                   add_en,
    output logic                   shift_en,
    output logic                   busy,
    output logic                   done,
    output logic [WORD_LENGTH-1:0] step,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WORD_LENGTH-1:0] STEP_LAST = WORD_LENGTH'(WORD_LENGTH - 1);
    localparam logic [WORD_LENGTH-1:0] STEP_ONE  = WORD_LENGTH'(1);

    state_t state;
    state_t state_nxt;

    // State register; reset drops straight to IDLE without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE, never queued.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (step == STEP_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath strobes decoded from state; add_en follows the multiplier LSB only while running.
    always_comb begin
        load     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            S_RUN: begin
                shift_en = 1'b1;
                add_en   = multiplier_lsb;
                busy     = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Iteration counter: zero from LOAD onward, counts through RUN and parks on the last index
    // so it never wraps and holds through DONE/IDLE until the next operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step <= '0;
        end else if (state_nxt == S_LOAD) begin
            step <= '0;
        end else if (state == S_RUN && step != STEP_LAST) begin
            step <= step + STEP_ONE;
        end
    end

`ifdef MULT_SEQ_ERR_EN
    logic err_q;

    // Sticky flag for a start request arriving while an operation is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (start && state != S_IDLE) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboarded bench for mult_sequencer: WORD_LENGTH=4 and WORD_LENGTH=8 instances.
// Stimulus pushes one expected record per busy cycle; negedge monitors pop and compare.
// Define MULT_SEQ_ERR_EN for both design and bench to exercise the err flag.
module tb_mult_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       lsb = 1'b0;
    logic       start8 = 1'b0;
    logic       lsb8 = 1'b0;

    logic       load, add_en, shift_en, busy, done, err;
    logic [3:0] step;
    logic       load8, add_en8, shift_en8, busy8, done8, err8;
    logic [7:0] step8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        load;
        logic        add;
        logic        shift;
        logic        done;
        logic [15:0] step;
    } rec_t;

    rec_t q4[$];
    rec_t q8[$];

    mult_sequencer #(.WORD_LENGTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .multiplier_lsb(lsb),
        .load(load), .add_en(add_en), .shift_en(shift_en), .busy(busy),
        .done(done), .step(step), .err(err)
    );

    mult_sequencer #(.WORD_LENGTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .multiplier_lsb(lsb8),
        .load(load8), .add_en(add_en8), .shift_en(shift_en8), .busy(busy8),
        .done(done8), .step(step8), .err(err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor for the 4-bit instance: every busy cycle must match the next queued record.
    always @(negedge clk) begin : mon4
        rec_t g;
        rec_t e;
        if (!reset) begin
            g = '{load, add_en, shift_en, done, 16'(step)};
            checks++;
            if (busy) begin
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL mon4 unexpected busy cycle got %h at %0t", g, $time);
                end else begin
                    e = q4.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL mon4 record got %h expected %h at %0t", g, e, $time);
                    end
                end
            end else if ({g.load, g.add, g.shift, g.done} !== 4'b0000) begin
                errors++;
                $display("FAIL mon4 idle strobes got %b expected 0000 at %0t",
                         {g.load, g.add, g.shift, g.done}, $time);
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin : mon8
        rec_t g;
        rec_t e;
        if (!reset) begin
            g = '{load8, add_en8, shift_en8, done8, 16'(step8)};
            checks++;
            if (busy8) begin
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL mon8 unexpected busy cycle got %h at %0t", g, $time);
                end else begin
                    e = q8.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL mon8 record got %h expected %h at %0t", g, e, $time);
                    end
                end
            end else if ({g.load, g.add, g.shift, g.done} !== 4'b0000) begin
                errors++;
                $display("FAIL mon8 idle strobes got %b expected 0000 at %0t",
                         {g.load, g.add, g.shift, g.done}, $time);
            end
        end
    end

    task automatic push(input int wl, input rec_t r);
        if (wl == 8) q8.push_back(r);
        else q4.push_back(r);
    endtask

    // One full operation. pat[i] is multiplier_lsb for RUN iteration i.
    // hold keeps start high throughout; poke>=0 pulses start during that RUN iteration.
    // Returns 1ns into the IDLE cycle following DONE.
    task automatic run_op(input int wl, input logic [15:0] pat, input bit hold, input int poke);
        if (wl == 8) start8 = 1'b1;
        else start = 1'b1;
        push(wl, '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
        for (int i = 0; i < wl; i++) push(wl, '{1'b0, pat[i], 1'b1, 1'b0, 16'(i)});
        push(wl, '{1'b0, 1'b0, 1'b0, 1'b1, 16'(wl - 1)});
        @(posedge clk); #1;
        if (!hold) begin
            start  = 1'b0;
            start8 = 1'b0;
        end
        for (int i = 0; i < wl; i++) begin
            @(posedge clk); #1;
            if (wl == 8) lsb8 = pat[i];
            else lsb = pat[i];
            if (poke >= 0) start = (i == poke);
        end
        @(posedge clk); #1;
        lsb  = 1'b0;
        lsb8 = 1'b0;
        if (wl != 8) start = hold;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset applied from time zero: outputs must be quiet before the first edge.
        #2;
        chk("rst_load", 16'(load), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_shift", 16'(shift_en), 16'd0);
        chk("rst_step", 16'(step), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        chk("rst_busy8", 16'(busy8), 16'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic operation, multiplier LSBs 1,0,1,1.
        run_op(4, 16'b1101, 1'b0, -1);
        chk("err_after_basic", 16'(err), 16'd0);

        // Start poked in RUN cycle 3 (iteration 1); operation must still complete on time.
        run_op(4, 16'b0110, 1'b0, 1);
`ifdef MULT_SEQ_ERR_EN
        chk("err_after_poke", 16'(err), 16'd1);
`else
        chk("err_after_poke", 16'(err), 16'd0);
`endif
        @(posedge clk); #1;
        chk("err_sticky", 16'(err),
`ifdef MULT_SEQ_ERR_EN
            16'd1
`else
            16'd0
`endif
        );

        // Reset asserted mid-RUN at step 2: abandons the operation with no done pulse.
        start = 1'b1;
        push(4, '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
        push(4, '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
        push(4, '{1'b0, 1'b1, 1'b1, 1'b0, 16'd1});
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; lsb = 1'b1;
        @(posedge clk); #1; lsb = 1'b1;
        @(posedge clk); #1; lsb = 1'b1;
        chk("midrun_step", 16'(step), 16'd2);
        chk("midrun_shift", 16'(shift_en), 16'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_busy", 16'(busy), 16'd0);
        chk("async_shift", 16'(shift_en), 16'd0);
        chk("async_add", 16'(add_en), 16'd0);
        chk("async_step", 16'(step), 16'd0);
        chk("async_err", 16'(err), 16'd0);
        chk("q4_drained_at_reset", 16'(q4.size()), 16'd0);
        q4.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lsb = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_done", 16'(done), 16'd0);

        // Full operation after reset release.
        run_op(4, 16'b1010, 1'b0, -1);

        // Start held high: back-to-back operations with one IDLE gap cycle.
        run_op(4, 16'b0011, 1'b1, -1);
        chk("gap_busy", 16'(busy), 16'd0);
        chk("gap_load", 16'(load), 16'd0);
        run_op(4, 16'b1001, 1'b0, -1);
        chk("hold_step_idle", 16'(step), 16'd3);

        // Eight-iteration instance.
        run_op(8, 16'b1011_0010, 1'b0, -1);
        chk("step8_final", 16'(step8), 16'd7);
        chk("err8", 16'(err8), 16'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("q4_empty", 16'(q4.size()), 16'd0);
        chk("q8_empty", 16'(q8.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
